// File: rtl/calc_pkg.sv
// Shared key codes, status/state encodings and
// elaboration helpers for the calculator core.
package calc_pkg;

  localparam logic [3:0] OP_ADD    = 4'hA;
  localparam logic [3:0] OP_SUB    = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;
  localparam logic [3:0] OP_DIV    = 4'hD;
  localparam logic [3:0] K_EQ      = 4'hE;
  localparam logic [3:0] K_BS      = 4'hF;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ERRO    = 2'd0,
    PRONTA  = 2'd1,
    OCUPADA = 2'd2
  } status_t;

  typedef enum logic [2:0] {
    ENT_A, ENT_B, MUL, DIV, CONV, EMIT, SHOW, ERR
  } state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Serial double-dabble binary to BCD converter,
// one shift per cycle, W shifts per conversion.
module calc_bin2bcd
  import calc_pkg::*;
#(
  parameter int W    = 32,
  parameter int NDIG = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      bin,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]      sh;
  logic [CW-1:0]     cnt;
  logic              busy;
  logic [4*NDIG-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // start folds the first shift into the load (adjust of zero is a no-op)
  always_ff @(posedge clock) begin
    if (reset) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd  <= {{(4*NDIG-1){1'b0}}, bin[W-1]};
        sh   <= {bin[W-2:0], 1'b0};
        cnt  <= CW'(W - 1);
        busy <= 1'b1;
      end else if (busy) begin
        bcd <= (4*NDIG)'({adj, sh[W-1]});
        sh  <= {sh[W-2:0], 1'b0};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_core_param.sv
// Multi-digit calculator core: key entry, add/sub,
// serial mul/div, BCD conversion and digit streaming.
module calc_core_param
  import calc_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int W    = 32,
  parameter int PW   = $clog2(NDIG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [1:0]    status,
  output logic [PW-1:0] pos,
  output logic [3:0]    dig,
  output logic          dig_valid,
  output logic          neg
);

  localparam longint unsigned MAXL = pow10(NDIG) - 1;
  localparam logic [W-1:0]    MAXV = W'(MAXL);
  localparam int              CW   = PW + 1;
  localparam int              NW   = $clog2(W + 1);
  localparam logic [CW-1:0]   NDC  = CW'(NDIG);

  if (MAXL >= (64'd1 << W)) begin : g_w_check
    $error("W too narrow for NDIG decimal digits");
  end

  state_t  state, state_n;
  status_t st;

  logic [W-1:0]  a, a_n, b, b_n, res, res_n;
  logic [W-1:0]  hi, hi_n, lo, lo_n, hi_st, lo_st;
  logic [CW-1:0] ca, ca_n, cb, cb_n, len, len_n;
  logic [CW-1:0] ecnt, ecnt_n, ccur, lz;
  logic [NW-1:0] cnt, cnt_n;
  logic [3:0]    op, op_n, dig_n;
  logic [PW-1:0] pos_n, eidx;
  logic          neg_n, dv_n, go, go_n, err;
  logic          cmd_ok, ent_b;
  logic          is_dig, is_op, is_eq, is_bs;
  logic [W-1:0]  cur, shl, shr, mag;
  logic [W:0]    mac, sh1, sum;
  logic          conv_done;
  logic [4*NDIG-1:0] bcd;
  logic [3:0]    bd [NDIG];

  calc_bin2bcd #(.W(W), .NDIG(NDIG)) u_bcd (
    .clock(clock),
    .reset(reset),
    .start(go),
    .bin  (res),
    .done (conv_done),
    .bcd  (bcd)
  );

  for (genvar g = 0; g < NDIG; g++) begin : g_bd
    assign bd[g] = bcd[4*g +: 4];
  end

  always_comb begin
    case (state)
      ERR:                  st = ERRO;
      MUL, DIV, CONV, EMIT: st = OCUPADA;
      default:              st = PRONTA;
    endcase
  end

  assign status = st;
  assign cmd_ok = cmd_valid && (st == PRONTA || state == ERR);
  assign is_dig = cmd <= 4'd9;
  assign is_op  = cmd >= OP_ADD && cmd <= OP_DIV;
  assign is_eq  = cmd == K_EQ;
  assign is_bs  = cmd == K_BS;

  assign ent_b = state == ENT_B;
  assign ccur  = ent_b ? cb : ca;
  assign cur   = ent_b ? b : a;
  assign shl   = cur * W'(10) + W'(cmd);
  assign shr   = cur / W'(10);
  assign sum   = {1'b0, a} + {1'b0, b};
  assign mag   = (a < b) ? b - a : a - b;
  assign eidx  = PW'(len - ecnt - CW'(1));

  // shared shift datapath: hi = accumulator / remainder
  assign mac = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
  assign sh1 = {hi, lo[W-1]};

  always_comb begin
    hi_st = hi;
    lo_st = lo;
    if (state == MUL) begin
      hi_st = mac[W:1];
      lo_st = {mac[0], lo[W-1:1]};
    end else if (sh1 >= {1'b0, b}) begin
      hi_st = W'(sh1 - {1'b0, b});
      lo_st = {lo[W-2:0], 1'b1};
    end else begin
      hi_st = sh1[W-1:0];
      lo_st = {lo[W-2:0], 1'b0};
    end
  end

  always_comb begin
    lz = CW'(1);
    for (int i = 1; i < NDIG; i++) begin
      if (bd[i] != 4'd0) lz = CW'(i + 1);
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    ca_n    = ca;
    cb_n    = cb;
    op_n    = op;
    res_n   = res;
    neg_n   = neg;
    hi_n    = hi;
    lo_n    = lo;
    cnt_n   = cnt;
    len_n   = len;
    ecnt_n  = ecnt;
    pos_n   = pos;
    dig_n   = dig;
    dv_n    = 1'b0;
    go_n    = 1'b0;
    err     = 1'b0;
    case (state)
      ENT_A, ENT_B: begin
        if (cmd_ok) begin
          unique case (1'b1)
            is_dig: begin
              if (ccur < NDC) begin
                if (ent_b) begin
                  b_n  = shl;
                  cb_n = cb + CW'(1);
                end else begin
                  a_n  = shl;
                  ca_n = ca + CW'(1);
                end
                pos_n = ccur[PW-1:0];
                dig_n = cmd;
                dv_n  = 1'b1;
              end
            end
            is_bs: begin
              if (ccur != '0) begin
                if (ent_b) begin
                  b_n  = shr;
                  cb_n = cb - CW'(1);
                end else begin
                  a_n  = shr;
                  ca_n = ca - CW'(1);
                end
                pos_n = PW'(ccur - CW'(1));
                dig_n = DIG_BLANK;
                dv_n  = 1'b1;
              end else if (ent_b) begin
                state_n = ENT_A;
                op_n    = '0;
              end
            end
            is_op: begin
              if (!ent_b && ca != '0) begin
                op_n    = cmd;
                state_n = ENT_B;
              end else if (ent_b && cb == '0) begin
                op_n = cmd;
              end
            end
            is_eq: begin
              if (!ent_b) begin
                res_n   = a;
                state_n = CONV;
                go_n    = 1'b1;
              end else if (cb != '0) begin
                case (op)
                  OP_ADD: begin
                    if (sum > {1'b0, MAXV}) err = 1'b1;
                    else begin
                      res_n   = sum[W-1:0];
                      state_n = CONV;
                      go_n    = 1'b1;
                    end
                  end
                  OP_SUB: begin
                    res_n   = mag;
                    neg_n   = a < b;
                    state_n = CONV;
                    go_n    = 1'b1;
                  end
                  OP_MUL: begin
                    hi_n    = '0;
                    lo_n    = b;
                    cnt_n   = NW'(W);
                    state_n = MUL;
                  end
                  default: begin
                    if (b == '0) err = 1'b1;
                    else begin
                      hi_n    = '0;
                      lo_n    = a;
                      cnt_n   = NW'(W);
                      state_n = DIV;
                    end
                  end
                endcase
              end
            end
          endcase
        end
      end
      MUL, DIV: begin
        hi_n  = hi_st;
        lo_n  = lo_st;
        cnt_n = cnt - NW'(1);
        if (cnt == NW'(1)) begin
          if (state == MUL && (hi_st != '0 || lo_st > MAXV)) err = 1'b1;
          else begin
            res_n   = lo_st;
            state_n = CONV;
            go_n    = 1'b1;
          end
        end
      end
      CONV: begin
        if (conv_done) begin
          len_n   = lz;
          ecnt_n  = '0;
          state_n = EMIT;
        end
      end
      EMIT: begin
        dv_n = 1'b1;
        if (ecnt < len) begin
          pos_n = eidx;
          dig_n = bd[eidx];
        end else begin
          pos_n = ecnt[PW-1:0];
          dig_n = DIG_BLANK;
        end
        if (ecnt == NDC - CW'(1)) state_n = SHOW;
        else ecnt_n = ecnt + CW'(1);
      end
      SHOW: begin
        if (cmd_ok) begin
          unique case (1'b1)
            is_dig, is_bs: begin
              a_n     = is_dig ? W'(cmd) : '0;
              ca_n    = is_dig ? CW'(1) : '0;
              b_n     = '0;
              cb_n    = '0;
              op_n    = '0;
              neg_n   = 1'b0;
              state_n = ENT_A;
              pos_n   = is_dig ? '0 : pos;
              dig_n   = is_dig ? cmd : dig;
              dv_n    = is_dig;
            end
            is_op: begin
              if (neg) err = 1'b1;
              else begin
                a_n     = res;
                ca_n    = len;
                b_n     = '0;
                cb_n    = '0;
                op_n    = cmd;
                state_n = ENT_B;
              end
            end
            is_eq: ;
          endcase
        end
      end
      ERR: begin
        if (cmd_ok && is_bs) begin
          a_n     = '0;
          b_n     = '0;
          ca_n    = '0;
          cb_n    = '0;
          op_n    = '0;
          neg_n   = 1'b0;
          state_n = ENT_A;
        end
      end
      default: state_n = ENT_A;
    endcase
    if (err) begin
      state_n = ERR;
      pos_n   = '0;
      dig_n   = DIG_BLANK;
      dv_n    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ENT_A;
      a         <= '0;
      b         <= '0;
      ca        <= '0;
      cb        <= '0;
      op        <= '0;
      res       <= '0;
      neg       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      len       <= '0;
      ecnt      <= '0;
      pos       <= '0;
      dig       <= '0;
      dig_valid <= 1'b0;
      go        <= 1'b0;
    end else begin
      state     <= state_n;
      a         <= a_n;
      b         <= b_n;
      ca        <= ca_n;
      cb        <= cb_n;
      op        <= op_n;
      res       <= res_n;
      neg       <= neg_n;
      hi        <= hi_n;
      lo        <= lo_n;
      cnt       <= cnt_n;
      len       <= len_n;
      ecnt      <= ecnt_n;
      pos       <= pos_n;
      dig       <= dig_n;
      dig_valid <= dv_n;
      go        <= go_n;
    end
  end

endmodule
